mem_responder: RTL

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_resp_types.sv | 23 ++
 rtl/mem_resp_array.sv | 32 +++
 rtl/mem_responder.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_resp_types.sv
// Shared types for the mem_responder slice: FSM states, the port selector and
// the width of the latency counter.
package mem_resp_types;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_RESP,
        ST_RECOVER
    } state_e;

    typedef enum logic {
        PORT_DATA,
        PORT_INSTR
    } port_e;

    localparam int CNT_W = 4;

    function automatic port_e other_port(input port_e p);
        return (p == PORT_DATA) ? PORT_INSTR : PORT_DATA;
    endfunction

endpackage

// File: rtl/mem_resp_array.sv
// Single-port word store with byte-enable writes and a registered read port.
// Contents have no reset so they survive a responder reset.
module mem_resp_array #(
    parameter int MEM_WORDS = 1024,
    parameter int AW        = $clog2(MEM_WORDS)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [3:0]    be_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [MEM_WORDS];
    logic [31:0] rdata_q;

    // Read-first: a read and write to the same word in one cycle returns the old word.
    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int b = 0; b < 4; b++) begin
                if (be_i[b]) begin
                    mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
        rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Two-port (instruction/data) memory responder with fixed response latency.
// Define MEM_RESPONDER_RR_EN for round-robin arbitration instead of data priority.
module mem_responder
    import mem_resp_types::*;
#(
    parameter int MEM_WORDS = 1024,
    parameter int LATENCY   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_read,
    input  logic [31:0] instr_mem_address,
    output logic        instr_mem_resp,
    output logic [31:0] instr_mem_rdata,
    input  logic        data_read,
    input  logic        data_write,
    input  logic [3:0]  data_mbe,
    input  logic [31:0] data_mem_address,
    input  logic [31:0] data_mem_wdata,
    output logic        data_mem_resp,
    output logic [31:0] data_mem_rdata
);

    localparam int AW = $clog2(MEM_WORDS);
    localparam logic [CNT_W-1:0] BUSY_LAST = CNT_W'((LATENCY > 1) ? LATENCY - 2 : 0);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    port_e             port_q, port_d;
    logic [AW-1:0]     idx_q, idx_d;
    logic [3:0]        mbe_q, mbe_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              wr_q, wr_d;
    logic [31:0]       instr_rdata_q, instr_rdata_d;
    logic [31:0]       data_rdata_q, data_rdata_d;

    logic              data_pend, instr_pend;
    logic              data_ok, instr_ok;
    logic              can_accept, accept, req_held;
    port_e             win;
    logic [AW-1:0]     data_idx, instr_idx;

    logic              arr_we;
    logic [AW-1:0]     arr_addr;
    logic [31:0]       arr_rdata;

    logic              unused_addr_bits;

    assign data_pend  = data_read | data_write;
    assign instr_pend = instr_read;
    assign data_idx   = data_mem_address[AW+1:2];
    assign instr_idx  = instr_mem_address[AW+1:2];

    assign unused_addr_bits = ^{data_mem_address[31:AW+2], data_mem_address[1:0],
                                instr_mem_address[31:AW+2], instr_mem_address[1:0]};

    // The port just served sits out its RECOVER cycle; the other port may be taken.
    assign can_accept = (state_q == ST_IDLE) || (state_q == ST_RECOVER);
    assign data_ok    = data_pend  && !((state_q == ST_RECOVER) && (port_q == PORT_DATA));
    assign instr_ok   = instr_pend && !((state_q == ST_RECOVER) && (port_q == PORT_INSTR));
    assign accept     = can_accept && (data_ok || instr_ok);
    assign req_held   = (port_q == PORT_DATA) ? data_pend : instr_pend;

`ifdef MEM_RESPONDER_RR_EN
    port_e prio_q, prio_d;

    assign win = (data_ok && instr_ok) ? prio_q : (data_ok ? PORT_DATA : PORT_INSTR);
`else
    assign win = data_ok ? PORT_DATA : PORT_INSTR;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            port_q        <= PORT_DATA;
            idx_q         <= '0;
            mbe_q         <= '0;
            wdata_q       <= '0;
            wr_q          <= 1'b0;
            instr_rdata_q <= '0;
            data_rdata_q  <= '0;
`ifdef MEM_RESPONDER_RR_EN
            prio_q        <= PORT_DATA;
`endif
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            port_q        <= port_d;
            idx_q         <= idx_d;
            mbe_q         <= mbe_d;
            wdata_q       <= wdata_d;
            wr_q          <= wr_d;
            instr_rdata_q <= instr_rdata_d;
            data_rdata_q  <= data_rdata_d;
`ifdef MEM_RESPONDER_RR_EN
            prio_q        <= prio_d;
`endif
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        port_d        = port_q;
        idx_d         = idx_q;
        mbe_d         = mbe_q;
        wdata_d       = wdata_q;
        wr_d          = wr_q;
        instr_rdata_d = instr_rdata_q;
        data_rdata_d  = data_rdata_q;
`ifdef MEM_RESPONDER_RR_EN
        prio_d        = prio_q;
`endif

        case (state_q)
            ST_IDLE, ST_RECOVER: begin
                state_d = ST_IDLE;
                if (accept) begin
                    port_d  = win;
                    idx_d   = (win == PORT_DATA) ? data_idx : instr_idx;
                    mbe_d   = data_mbe;
                    wdata_d = data_mem_wdata;
                    wr_d    = (win == PORT_DATA) && data_write;
                    cnt_d   = '0;
                    state_d = (LATENCY == 1) ? ST_RESP : ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (!req_held) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == BUSY_LAST) begin
                    state_d = ST_RESP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RESP: begin
                state_d = ST_RECOVER;
                if (!wr_q) begin
                    if (port_q == PORT_DATA) begin
                        data_rdata_d = arr_rdata;
                    end else begin
                        instr_rdata_d = arr_rdata;
                    end
                end
`ifdef MEM_RESPONDER_RR_EN
                prio_d = other_port(port_q);
`endif
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // The array is addressed with the new index on the accept edge so that,
    // for LATENCY=1, the read word is ready in the RESP cycle.
    always_comb begin
        instr_mem_resp  = 1'b0;
        data_mem_resp   = 1'b0;
        instr_mem_rdata = instr_rdata_q;
        data_mem_rdata  = data_rdata_q;
        arr_we          = 1'b0;
        arr_addr        = idx_q;

        if (accept) begin
            arr_addr = (win == PORT_DATA) ? data_idx : instr_idx;
        end

        if (state_q == ST_RESP) begin
            if (port_q == PORT_DATA) begin
                data_mem_resp = 1'b1;
                arr_we        = wr_q;
                if (!wr_q) begin
                    data_mem_rdata = arr_rdata;
                end
            end else begin
                instr_mem_resp  = 1'b1;
                instr_mem_rdata = arr_rdata;
            end
        end
    end

    mem_resp_array #(
        .MEM_WORDS (MEM_WORDS),
        .AW        (AW)
    ) u_array (
        .clk     (clk),
        .we_i    (arr_we),
        .be_i    (mbe_q),
        .addr_i  (arr_addr),
        .wdata_i (wdata_q),
        .rdata_o (arr_rdata)
    );

endmodule
